// File: rtl/huff_tree_if.sv
// Handshake bundle between the tree builder and its neighbours.
//   Input side : serial tree bits (in_bit/in_valid/in_ready).
//   Output side: decode-table writes (out_code/out_len/out_addr/out_valid/out_ready).
// Modports: slave = tree builder, master = bit source / table sink.
interface huff_tree_if #(
  parameter int SYM_W   = 4,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) ();
  logic               in_bit;
  logic               in_valid;
  logic               in_ready;
  logic [MAX_LEN-1:0] out_code;
  logic [LEN_W-1:0]   out_len;
  logic [SYM_W-1:0]   out_addr;
  logic               out_valid;
  logic               out_ready;

  modport slave (
    input  in_bit, in_valid, out_ready,
    output in_ready, out_code, out_len, out_addr, out_valid
  );

  modport master (
    output in_bit, in_valid, out_ready,
    input  in_ready, out_code, out_len, out_addr, out_valid
  );
endinterface

// File: rtl/huff_tree_builder.sv
// Decodes a serial preorder Huffman tree description into one {symbol, code, length}
//   decode-table write per leaf. Latency: a write is offered the cycle after the last
//   symbol bit is taken. Backpressure: in_ready drops while a write waits on out_ready.
// Ports: CLK, Reset (async, active-low), EN (synchronous hold), clear (synchronous restart,
//   ignores EN), bus (huff_tree_if.slave: bit input + table-write output), leaf_cnt, done, error.
// Option: define HUFF_DUP_CHECK_EN to reject trees that name the same symbol twice.
module huff_tree_builder #(
  parameter int SYM_W   = 4,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic           CLK,
  input  logic           Reset,
  input  logic           EN,
  input  logic           clear,
  huff_tree_if.slave     bus,
  output logic [SYM_W:0] leaf_cnt,
  output logic           done,
  output logic           error
);

  localparam int ALPHA = 1 << SYM_W;
  localparam int BC_W  = $clog2(SYM_W + 1);

  typedef enum logic [2:0] {
    TRAVERSE,
    SYMBOL,
    EMIT,
    DONE,
    ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] code_q, code_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [SYM_W-1:0]   sym_q, sym_d;
  logic [BC_W-1:0]    bcnt_q, bcnt_d;
  logic [SYM_W:0]     cnt_q, cnt_d;
`ifdef HUFF_DUP_CHECK_EN
  logic [ALPHA-1:0]   seen_q, seen_d;
`endif

  logic               in_ready_w;
  logic               take_bit;
  logic               take_out;
  logic [SYM_W-1:0]   sym_full;
  logic [LEN_W-1:0]   ones;
  logic               in_run;

  // Gating with Reset keeps in_ready low while reset is asserted, like every other output.
  assign in_ready_w = Reset && EN && (state_q == TRAVERSE || state_q == SYMBOL);
  assign take_bit   = bus.in_valid && in_ready_w;
  assign take_out   = EN && (state_q == EMIT) && bus.out_ready;

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    len_d    = len_q;
    sym_d    = sym_q;
    bcnt_d   = bcnt_q;
    cnt_d    = cnt_q;
`ifdef HUFF_DUP_CHECK_EN
    seen_d   = seen_q;
`endif
    sym_full = SYM_W'({sym_q, bus.in_bit});

    // Trailing ones of the code. Bits above len are always zero, so the count never
    // exceeds len, and ones == len means the path is all right-turns (tree closed).
    ones   = '0;
    in_run = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (in_run && code_q[i]) begin
        ones = ones + LEN_W'(1);
      end else begin
        in_run = 1'b0;
      end
    end

    if (clear) begin
      state_d = TRAVERSE;
      code_d  = '0;
      len_d   = '0;
      sym_d   = '0;
      bcnt_d  = '0;
      cnt_d   = '0;
`ifdef HUFF_DUP_CHECK_EN
      seen_d  = '0;
`endif
    end else begin
      case (state_q)
        TRAVERSE: begin
          if (take_bit) begin
            if (!bus.in_bit) begin
              // Internal node: descend left.
              if (len_q == LEN_W'(MAX_LEN)) begin
                state_d = ERROR;
              end else begin
                code_d = code_q << 1;
                len_d  = len_q + LEN_W'(1);
              end
            end else if (cnt_q == ALPHA[SYM_W:0]) begin
              state_d = ERROR;
            end else begin
              state_d = SYMBOL;
              sym_d   = '0;
              bcnt_d  = '0;
            end
          end
        end

        SYMBOL: begin
          if (take_bit) begin
            sym_d  = sym_full;
            bcnt_d = bcnt_q + BC_W'(1);
            if (bcnt_q == BC_W'(SYM_W - 1)) begin
`ifdef HUFF_DUP_CHECK_EN
              if (seen_q[sym_full]) begin
                state_d = ERROR;
              end else begin
                state_d          = EMIT;
                seen_d[sym_full] = 1'b1;
              end
`else
              state_d = EMIT;
`endif
            end
          end
        end

        EMIT: begin
          if (take_out) begin
            cnt_d = cnt_q + (SYM_W + 1)'(1);
            if (ones == len_q) begin
              state_d = DONE;
            end else begin
              // Climb past the finished right subtrees, then step to the right sibling.
              code_d  = (code_q >> ones) | MAX_LEN'(1);
              len_d   = len_q - ones;
              state_d = TRAVERSE;
            end
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= TRAVERSE;
      code_q  <= '0;
      len_q   <= '0;
      sym_q   <= '0;
      bcnt_q  <= '0;
      cnt_q   <= '0;
`ifdef HUFF_DUP_CHECK_EN
      seen_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      len_q   <= len_d;
      sym_q   <= sym_d;
      bcnt_q  <= bcnt_d;
      cnt_q   <= cnt_d;
`ifdef HUFF_DUP_CHECK_EN
      seen_q  <= seen_d;
`endif
    end
  end

  // code/len/sym are frozen in EMIT, so they serve directly as the table-write payload.
  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_code  = code_q;
  assign bus.out_len   = len_q;
  assign bus.out_addr  = sym_q;
  assign leaf_cnt      = cnt_q;
  assign done          = (state_q == DONE);
  assign error         = (state_q == ERROR);

endmodule

// File: tb/tb_huff_tree_builder.sv
// Directed bench for huff_tree_builder (SYM_W=4, MAX_LEN=16, LEN_W=5).
//   Table of whole-tree streams with hand-computed writes, plus sequences for stalls,
//   input gaps, reset/clear mid-stream, EN low during a pending write and clear in EMIT.
module tb_huff_tree_builder;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       EN;
  logic       clear;
  logic [4:0] leaf_cnt;
  logic       done;
  logic       error;

  always #5 CLK = ~CLK;

  huff_tree_if #(.SYM_W(4), .MAX_LEN(16), .LEN_W(5)) bf ();

  huff_tree_builder #(.SYM_W(4), .MAX_LEN(16), .LEN_W(5)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .EN       (EN),
    .clear    (clear),
    .bus      (bf),
    .leaf_cnt (leaf_cnt),
    .done     (done),
    .error    (error)
  );

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] code;
    logic [4:0]  len;
  } wr_t;

  typedef struct {
    string       name;
    logic [63:0] bits;
    int          nbits;
    int          nwr;
    wr_t         wr [3];
    logic        exp_done;
    logic        exp_err;
    int          exp_cnt;
  } vec_t;

  vec_t tbl [4];
  wr_t  got [$];
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   stable_ok;

  function automatic wr_t mk(input int a, input int c, input int l);
    wr_t w;
    w.addr = 4'(a);
    w.code = 16'(c);
    w.len  = 5'(l);
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic do_clear();
    @(negedge CLK);
    bf.in_valid  = 1'b0;
    bf.out_ready = 1'b0;
    clear        = 1'b1;
    @(negedge CLK);
    clear = 1'b0;
  endtask

  // Offer bits back to back; leaves in_valid low afterwards.
  task automatic feed(input logic [63:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      bf.in_valid = 1'b1;
      bf.in_bit   = bits[n-1-i];
    end
    @(negedge CLK);
    bf.in_valid = 1'b0;
  endtask

  // Streams a tree, then keeps offering 0 bits; collects table writes until the tree ends.
  task automatic run(input logic [63:0] bits, input int n, input int stall, input bit gaps,
                     output int consumed);
    int  idx = 0;
    int  cyc = 0;
    int  hold = 0;
    int  settle = 0;
    bit  have_snap = 1'b0;
    wr_t snap;
    wr_t cur;
    got.delete();
    stable_ok = 1'b1;
    while (cyc < 3000 && settle < 4) begin
      @(negedge CLK);
      bf.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bf.in_bit   = (idx < n) ? bits[n-1-idx] : 1'b0;
      cur = {bf.out_addr, bf.out_code, bf.out_len};
      if (bf.out_valid) begin
        if (!have_snap) begin
          snap      = cur;
          have_snap = 1'b1;
          hold      = 0;
        end else if (cur != snap) begin
          stable_ok = 1'b0;
        end
        bf.out_ready = (hold >= stall);
        hold++;
      end else begin
        bf.out_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      #1;
      if (bf.out_valid && bf.in_ready) stable_ok = 1'b0;
      if (bf.in_valid && bf.in_ready) idx++;
      if (bf.out_valid && bf.out_ready) begin
        got.push_back(cur);
        have_snap = 1'b0;
      end
      if (done || error) settle++;
      cyc++;
    end
    n_chk++;
    if (settle < 4) $display("FAIL run timeout: tree never closed after %0d cycles", cyc);
    else n_pass++;
    @(negedge CLK);
    bf.in_valid  = 1'b0;
    bf.out_ready = 1'b0;
    consumed = idx;
  endtask

  task automatic verify(input vec_t v, input string tag, input int consumed);
    logic [63:0] a;
    chk({tag, " writes"}, 64'(got.size()), 64'(v.nwr));
    for (int i = 0; i < v.nwr; i++) begin
      a = '1;
      if (i < got.size()) a = 64'(got[i]);
      chk($sformatf("%s write%0d", tag, i), a, 64'(v.wr[i]));
    end
    chk({tag, " done"},     64'(done),        64'(v.exp_done));
    chk({tag, " error"},    64'(error),       64'(v.exp_err));
    chk({tag, " leaf_cnt"}, 64'(leaf_cnt),    64'(v.exp_cnt));
    chk({tag, " in_ready"}, 64'(bf.in_ready), 64'(0));
    chk({tag, " consumed"}, 64'(consumed),    64'(v.nbits));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cons;

    Reset        = 1'b0;
    EN           = 1'b1;
    clear        = 1'b0;
    bf.in_valid  = 1'b0;
    bf.in_bit    = 1'b0;
    bf.out_ready = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset outputs", 64'({bf.out_valid, bf.in_ready, done, error, leaf_cnt,
                              bf.out_code, bf.out_len, bf.out_addr}), 64'(0));
    Reset = 1'b1;
    #1;
    chk("ready after reset", 64'(bf.in_ready), 64'(1));

    // case 1: three leaves, depth 1 and 2
    tbl[0].name = "case1"; tbl[0].bits = 64'(17'b0_1_0011_0_1_0101_1_1001); tbl[0].nbits = 17;
    tbl[0].nwr = 3; tbl[0].wr[0] = mk(3, 0, 1); tbl[0].wr[1] = mk(5, 2, 2); tbl[0].wr[2] = mk(9, 3, 2);
    tbl[0].exp_done = 1'b1; tbl[0].exp_err = 1'b0; tbl[0].exp_cnt = 3;
    // case 2: single-symbol tree, root leaf
    tbl[1].name = "case2"; tbl[1].bits = 64'(5'b1_0111); tbl[1].nbits = 5;
    tbl[1].nwr = 1; tbl[1].wr[0] = mk(7, 0, 0); tbl[1].wr[1] = '0; tbl[1].wr[2] = '0;
    tbl[1].exp_done = 1'b1; tbl[1].exp_err = 1'b0; tbl[1].exp_cnt = 1;
    // case 3: 17 internal nodes overflow the 16-bit code
    tbl[2].name = "case3"; tbl[2].bits = 64'(0); tbl[2].nbits = 17;
    tbl[2].nwr = 0; tbl[2].wr[0] = '0; tbl[2].wr[1] = '0; tbl[2].wr[2] = '0;
    tbl[2].exp_done = 1'b0; tbl[2].exp_err = 1'b1; tbl[2].exp_cnt = 0;
    // case 6: the same symbol named twice
    tbl[3].name = "case6"; tbl[3].bits = 64'(11'b0_1_0011_1_0011); tbl[3].nbits = 11;
    tbl[3].wr[0] = mk(3, 0, 1); tbl[3].wr[2] = '0;
`ifdef HUFF_DUP_CHECK_EN
    tbl[3].nwr = 1; tbl[3].wr[1] = '0;
    tbl[3].exp_done = 1'b0; tbl[3].exp_err = 1'b1; tbl[3].exp_cnt = 1;
`else
    tbl[3].nwr = 2; tbl[3].wr[1] = mk(3, 1, 1);
    tbl[3].exp_done = 1'b1; tbl[3].exp_err = 1'b0; tbl[3].exp_cnt = 2;
`endif

    for (int k = 0; k < 4; k++) begin
      do_clear();
      run(tbl[k].bits, tbl[k].nbits, 0, 1'b0, cons);
      verify(tbl[k], tbl[k].name, cons);
    end

    // case 4: table writes held off 5 cycles each, then with random input gaps too
    do_clear();
    run(tbl[0].bits, tbl[0].nbits, 5, 1'b0, cons);
    verify(tbl[0], "stall", cons);
    chk("stall stable", 64'(stable_ok), 64'(1));
    do_clear();
    run(tbl[0].bits, tbl[0].nbits, 2, 1'b1, cons);
    verify(tbl[0], "gaps", cons);
    chk("gaps stable", 64'(stable_ok), 64'(1));

    // case 5a: reset while mid-SYMBOL
    do_clear();
    feed(64'(3'b010), 3);
    Reset = 1'b0;
    #1;
    chk("reset mid-symbol outputs", 64'({bf.out_valid, bf.in_ready, done, error, leaf_cnt,
                                         bf.out_code, bf.out_len, bf.out_addr}), 64'(0));
    @(negedge CLK);
    Reset = 1'b1;
    run(tbl[0].bits, tbl[0].nbits, 0, 1'b0, cons);
    verify(tbl[0], "after reset", cons);

    // case 5b: clear while mid-SYMBOL, with EN low to show clear ignores EN
    do_clear();
    feed(64'(3'b010), 3);
    EN    = 1'b0;
    clear = 1'b1;
    @(negedge CLK);
    clear = 1'b0;
    chk("clear mid-symbol state", 64'({bf.out_len, bf.out_addr, leaf_cnt, bf.in_ready}), 64'(0));
    EN = 1'b1;
    run(tbl[0].bits, tbl[0].nbits, 0, 1'b0, cons);
    verify(tbl[0], "after clear", cons);

    // EN low while a write is pending: accept ignored until EN returns
    do_clear();
    feed(64'(6'b0_1_0011), 6);
    EN           = 1'b0;
    bf.out_ready = 1'b1;
    repeat (3) @(negedge CLK);
    chk("en-low valid held", 64'(bf.out_valid), 64'(1));
    chk("en-low no accept",  64'(leaf_cnt),     64'(0));
    chk("en-low payload",    64'({bf.out_addr, bf.out_code, bf.out_len}), 64'(mk(3, 0, 1)));
    EN = 1'b1;
    @(negedge CLK);
    chk("en-high accept", 64'({bf.out_valid, leaf_cnt}), 64'({1'b0, 5'd1}));
    bf.out_ready = 1'b0;

    // clear during EMIT drops the pending write
    do_clear();
    feed(tbl[1].bits, 5);
    chk("emit pending", 64'(bf.out_valid), 64'(1));
    clear = 1'b1;
    @(negedge CLK);
    clear        = 1'b0;
    bf.out_ready = 1'b1;
    chk("emit dropped", 64'({bf.out_valid, done, leaf_cnt}), 64'(0));
    repeat (3) @(negedge CLK);
    chk("no late write", 64'({leaf_cnt, done}), 64'(0));
    bf.out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
